// File: rtl/falafel_pkg.sv
// falafel_pkg: shared widths, allocator entry type and queue-ID helper
package falafel_pkg;

   localparam int DATA_W       = 8;
   localparam int MSG_ID_SIZE  = 4;
   localparam int INBUF_MAX_CH = 2 ** MSG_ID_SIZE;

   typedef struct packed {
      logic [MSG_ID_SIZE-1:0] queue_id;
      logic [DATA_W-1:0]      data;
   } alloc_entry_t;

   function automatic logic [MSG_ID_SIZE-1:0] ch_queue_id(input logic [MSG_ID_SIZE-1:0] base, input int idx);
      return base + MSG_ID_SIZE'(idx);
   endfunction

endpackage

// File: rtl/falafel_rr_arbiter.sv
// falafel_rr_arbiter: round-robin grant over NUM_CH requesters, owns the RR pointer
module falafel_rr_arbiter #(
   parameter int NUM_CH = 2,
   localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [NUM_CH-1:0] req_i,
   input  logic              advance_i,
   output logic [NUM_CH-1:0] gnt_o,
   output logic [IDX_W-1:0]  gnt_idx_o
);

   logic [IDX_W-1:0] ptr_q, ptr_d;

   // Pick the first requester at or after the pointer; nearer offsets are assigned last and win
   always_comb begin
      gnt_idx_o = '0;
      for (int k = NUM_CH - 1; k >= 0; k--)
         for (int n = 0; n < NUM_CH; n++)
            if (req_i[n] && n == (int'(ptr_q) + k) % NUM_CH) gnt_idx_o = IDX_W'(n);
      gnt_o = (|req_i) ? (NUM_CH'(1) << gnt_idx_o) : '0;
      ptr_d = (advance_i && |req_i) ? ((int'(gnt_idx_o) == NUM_CH - 1) ? '0 : gnt_idx_o + 1'b1) : ptr_q;
   end

   // Pointer moves past the winner only when a grant is consumed
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) ptr_q <= '0;
      else       ptr_q <= ptr_d;
   end

endmodule

// File: rtl/falafel_multi_input_buffer.sv
// falafel_multi_input_buffer: per-channel FIFOs merged round-robin onto one registered alloc_entry_t stream (FALAFEL_INBUF_OCCUPANCY_EN adds occupancy_o/drop_err_o)
module falafel_multi_input_buffer
   import falafel_pkg::*;
#(
   parameter int                     NUM_CH        = 2,
   parameter int                     FIFO_DEPTH    = 2,
   parameter logic [MSG_ID_SIZE-1:0] BASE_QUEUE_ID = MSG_ID_SIZE'(0)
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [NUM_CH-1:0]        req_val_i,
   output logic [NUM_CH-1:0]        req_rdy_o,
   input  logic [NUM_CH*DATA_W-1:0] req_data_i,
   output logic                     buffered_req_val_o,
   input  logic                     buffered_req_rdy_i,
   output alloc_entry_t             buffered_req_data_o
`ifdef FALAFEL_INBUF_OCCUPANCY_EN
   ,
   output logic [NUM_CH*$clog2(FIFO_DEPTH+1)-1:0] occupancy_o,
   output logic [NUM_CH-1:0]                      drop_err_o
`endif
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   if (NUM_CH < 1 || FIFO_DEPTH < 2 || int'(BASE_QUEUE_ID) + NUM_CH > INBUF_MAX_CH) begin : g_bad_cfg
      $error("falafel_multi_input_buffer: illegal NUM_CH/FIFO_DEPTH/BASE_QUEUE_ID");
   end

   logic [NUM_CH-1:0] nonempty;
   logic [NUM_CH-1:0] gnt;
   logic [IDX_W-1:0]  gnt_idx;
   logic [DATA_W-1:0] head [NUM_CH];
   logic              load_en;
   logic              val_q, val_d;
   alloc_entry_t      data_q, data_d;

   assign load_en = !val_q || buffered_req_rdy_i;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic [PTR_W-1:0]  wr_q, wr_d, rd_q, rd_d;
      logic [CNT_W-1:0]  cnt_q, cnt_d;
      logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
      logic              push, pop;

      assign req_rdy_o[c] = cnt_q != CNT_W'(FIFO_DEPTH);
      assign nonempty[c]  = cnt_q != '0;
      assign push         = req_val_i[c] && req_rdy_o[c];
      assign pop          = load_en && gnt[c];
      assign head[c]      = mem_q[rd_q];

      // Pointer wrap at FIFO_DEPTH and count tracking for this channel
      always_comb begin
         wr_d  = push ? ((wr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_q + 1'b1) : wr_q;
         rd_d  = pop ? ((rd_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_q + 1'b1) : rd_q;
         cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
      end

      // FIFO control state, cleared by reset so buffered entries are discarded
      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
         end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
         end
      end

      // Payload storage needs no reset; only slots below the count are ever read
      always_ff @(posedge clk_i) begin
         if (push) mem_q[wr_q] <= req_data_i[c*DATA_W +: DATA_W];
      end

`ifdef FALAFEL_INBUF_OCCUPANCY_EN
      logic drop_q;

      assign occupancy_o[c*CNT_W +: CNT_W] = cnt_q;
      assign drop_err_o[c]                 = drop_q;

      // Sticky record of a valid presented while the FIFO was full
      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) drop_q <= 1'b0;
         else       drop_q <= drop_q || (req_val_i[c] && !req_rdy_o[c]);
      end
`endif
   end

   falafel_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .req_i     (nonempty),
      .advance_i (load_en),
      .gnt_o     (gnt),
      .gnt_idx_o (gnt_idx)
   );

   // Output register refills whenever it is empty or being consumed; holds during stall
   always_comb begin
      val_d  = load_en ? |nonempty : val_q;
      data_d = (load_en && |nonempty) ? {ch_queue_id(BASE_QUEUE_ID, int'(gnt_idx)), head[gnt_idx]} : data_q;
   end

   // Registered output stage, so no input reaches the output combinationally
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         val_q  <= 1'b0;
         data_q <= '0;
      end else begin
         val_q  <= val_d;
         data_q <= data_d;
      end
   end

   assign buffered_req_val_o  = val_q;
   assign buffered_req_data_o = data_q;

endmodule

// File: tb/tb_falafel_multi_input_buffer.sv
// tb_falafel_multi_input_buffer: directed checks of buffering, round-robin merge, stall and reset
module tb_falafel_multi_input_buffer;
   import falafel_pkg::*;

   logic                clk_i = 1'b0;
   logic                rst_i = 1'b1;
   logic [1:0]          req_val_i = '0;
   logic [1:0]          req_rdy_o;
   logic [2*DATA_W-1:0] req_data_i = '0;
   logic                buffered_req_val_o;
   logic                buffered_req_rdy_i = 1'b0;
   alloc_entry_t        buffered_req_data_o;
`ifdef FALAFEL_INBUF_OCCUPANCY_EN
   logic [3:0]          occupancy_o;
   logic [1:0]          drop_err_o;
`endif

   int passed = 0;
   int total  = 0;

   falafel_multi_input_buffer #(
      .NUM_CH        (2),
      .FIFO_DEPTH    (2),
      .BASE_QUEUE_ID (4'd4)
   ) dut (
      .clk_i               (clk_i),
      .rst_i               (rst_i),
      .req_val_i           (req_val_i),
      .req_rdy_o           (req_rdy_o),
      .req_data_i          (req_data_i),
      .buffered_req_val_o  (buffered_req_val_o),
      .buffered_req_rdy_i  (buffered_req_rdy_i),
      .buffered_req_data_o (buffered_req_data_o)
`ifdef FALAFEL_INBUF_OCCUPANCY_EN
      ,
      .occupancy_o         (occupancy_o),
      .drop_err_o          (drop_err_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic apply_reset();
      rst_i = 1'b1;
      req_val_i = '0;
      req_data_i = '0;
      buffered_req_rdy_i = 1'b0;
      step();
      step();
      rst_i = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset();
      step();
      total++;
      if (req_rdy_o !== 2'b11) $display("FAIL reset_rdy: got %b want 11", req_rdy_o);
      else passed++;
      total++;
      if (buffered_req_val_o !== 1'b0) $display("FAIL reset_val: got %b want 0", buffered_req_val_o);
      else passed++;
      total++;
      if (buffered_req_data_o !== 12'h000) $display("FAIL reset_data: got %h want 000", buffered_req_data_o);
      else passed++;
   endtask

   task automatic test_single_write();
      apply_reset();
      buffered_req_rdy_i = 1'b1;
      req_val_i = 2'b01;
      req_data_i = 16'h000A;
      step();
      req_val_i = '0;
      total++;
      if (buffered_req_val_o !== 1'b0) $display("FAIL single_latency: val got %b want 0", buffered_req_val_o);
      else passed++;
      step();
      total++;
      if (buffered_req_val_o !== 1'b1) $display("FAIL single_val: got %b want 1", buffered_req_val_o);
      else passed++;
      total++;
      if (buffered_req_data_o !== 12'h40A) $display("FAIL single_data: got %h want 40a", buffered_req_data_o);
      else passed++;
      step();
      total++;
      if (buffered_req_val_o !== 1'b0) $display("FAIL single_clear: val got %b want 0", buffered_req_val_o);
      else passed++;
   endtask

   task automatic test_round_robin();
      logic [11:0] exp [4];
      exp[0] = 12'h410; exp[1] = 12'h520; exp[2] = 12'h411; exp[3] = 12'h521;
      apply_reset();
      buffered_req_rdy_i = 1'b1;
      req_val_i = 2'b11;
      req_data_i = 16'h2010;
      step();
      req_data_i = 16'h2111;
      step();
      req_val_i = '0;
      for (int i = 0; i < 4; i++) begin
         total++;
         if (buffered_req_val_o !== 1'b1 || buffered_req_data_o !== exp[i])
            $display("FAIL rr_order[%0d]: got val=%b data=%h want val=1 data=%h", i, buffered_req_val_o, buffered_req_data_o, exp[i]);
         else passed++;
         step();
      end
      total++;
      if (buffered_req_val_o !== 1'b0) $display("FAIL rr_drained: val got %b want 0", buffered_req_val_o);
      else passed++;
   endtask

   task automatic test_stall();
      apply_reset();
      buffered_req_rdy_i = 1'b0;
      req_val_i = 2'b10;
      for (int i = 0; i < 3; i++) begin
         req_data_i = {8'h30 + 8'(i), 8'h00};
         step();
      end
      total++;
      if (req_rdy_o[1] !== 1'b0) $display("FAIL stall_full: rdy1 got %b want 0", req_rdy_o[1]);
      else passed++;
`ifdef FALAFEL_INBUF_OCCUPANCY_EN
      total++;
      if (occupancy_o !== 4'b1000) $display("FAIL stall_occupancy: got %h want 8", occupancy_o);
      else passed++;
`endif
      req_data_i = 16'h3300;
      step();
      req_val_i = '0;
`ifdef FALAFEL_INBUF_OCCUPANCY_EN
      total++;
      if (drop_err_o !== 2'b10) $display("FAIL stall_drop: got %b want 10", drop_err_o);
      else passed++;
`endif
      step();
      total++;
      if (buffered_req_val_o !== 1'b1 || buffered_req_data_o !== 12'h530)
         $display("FAIL stall_hold: got val=%b data=%h want val=1 data=530", buffered_req_val_o, buffered_req_data_o);
      else passed++;
      buffered_req_rdy_i = 1'b1;
      step();
      total++;
      if (buffered_req_data_o !== 12'h531 || req_rdy_o[1] !== 1'b1)
         $display("FAIL stall_drain1: got data=%h rdy1=%b want data=531 rdy1=1", buffered_req_data_o, req_rdy_o[1]);
      else passed++;
      step();
      total++;
      if (buffered_req_val_o !== 1'b1 || buffered_req_data_o !== 12'h532)
         $display("FAIL stall_drain2: got val=%b data=%h want val=1 data=532", buffered_req_val_o, buffered_req_data_o);
      else passed++;
      step();
      total++;
      if (buffered_req_val_o !== 1'b0) $display("FAIL stall_no_extra: val got %b want 0", buffered_req_val_o);
      else passed++;
   endtask

   task automatic test_back_to_back();
      apply_reset();
      buffered_req_rdy_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         req_val_i = 2'b10;
         req_data_i = {8'h40 + 8'(i), 8'h00};
         step();
         if (i >= 1) begin
            total++;
            if (buffered_req_val_o !== 1'b1 || buffered_req_data_o !== {4'd5, 8'h40 + 8'(i - 1)})
               $display("FAIL b2b[%0d]: got val=%b data=%h want val=1 data=%h", i - 1, buffered_req_val_o, buffered_req_data_o, {4'd5, 8'h40 + 8'(i - 1)});
            else passed++;
         end
      end
      req_val_i = '0;
      step();
      total++;
      if (buffered_req_val_o !== 1'b1 || buffered_req_data_o !== 12'h543)
         $display("FAIL b2b[3]: got val=%b data=%h want val=1 data=543", buffered_req_val_o, buffered_req_data_o);
      else passed++;
      step();
      total++;
      if (buffered_req_val_o !== 1'b0) $display("FAIL b2b_end: val got %b want 0", buffered_req_val_o);
      else passed++;
   endtask

   task automatic test_mid_reset();
      apply_reset();
      buffered_req_rdy_i = 1'b0;
      req_val_i = 2'b01;
      req_data_i = 16'h0050;
      step();
      req_val_i = 2'b11;
      req_data_i = 16'h6051;
      step();
      req_val_i = '0;
      total++;
      if (buffered_req_val_o !== 1'b1 || buffered_req_data_o !== 12'h450)
         $display("FAIL midrst_pre: got val=%b data=%h want val=1 data=450", buffered_req_val_o, buffered_req_data_o);
      else passed++;
      #2;
      rst_i = 1'b1;
      #1;
      total++;
      if (buffered_req_val_o !== 1'b0 || buffered_req_data_o !== 12'h000 || req_rdy_o !== 2'b11)
         $display("FAIL midrst_async: got val=%b data=%h rdy=%b want 0/000/11", buffered_req_val_o, buffered_req_data_o, req_rdy_o);
      else passed++;
`ifdef FALAFEL_INBUF_OCCUPANCY_EN
      total++;
      if (occupancy_o !== 4'h0 || drop_err_o !== 2'b00)
         $display("FAIL midrst_occ: got occ=%h drop=%b want 0/00", occupancy_o, drop_err_o);
      else passed++;
`endif
      step();
      rst_i = 1'b0;
      buffered_req_rdy_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         total++;
         if (buffered_req_val_o !== 1'b0) $display("FAIL midrst_stale[%0d]: val got %b want 0", i, buffered_req_val_o);
         else passed++;
      end
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_round_robin();
      test_stall();
      test_back_to_back();
      test_mid_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/falafel_multi_input_buffer.md
Name: falafel_multi_input_buffer

Overview:
Multi-channel successor to the single-channel request input buffer. Accepts NUM_CH independent valid/ready request streams and buffers each in its own FIFO of depth FIFO_DEPTH. Each entry is tagged with its channel's queue ID (BASE_QUEUE_ID + channel index). Buffered entries are merged onto one registered alloc_entry_t output stream by a round-robin arbiter. Sits between the request ports and the allocator core.

Parameters:
NUM_CH, 2, number of request channels (1..2**MSG_ID_SIZE - BASE_QUEUE_ID)
FIFO_DEPTH, 2, entries per channel FIFO (>=2, power of two not required)
BASE_QUEUE_ID, MSG_ID_SIZE'(0), queue ID of channel 0; channel i tags with BASE_QUEUE_ID+i

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
req_val_i  in  NUM_CH  per-channel request valid
req_rdy_o  out  NUM_CH  per-channel ready (= channel FIFO not full)
req_data_i  in  NUM_CH x DATA_W  per-channel request payload
buffered_req_val_o  out  1  output entry valid (registered)
buffered_req_rdy_i  in  1  downstream ready
buffered_req_data_o  out  alloc_entry_t  {queue ID, payload}

Behaviour:
- Reset (async assert, sync-safe deassert by system): all FIFOs empty; req_rdy_o = all ones; buffered_req_val_o = 0; buffered_req_data_o = 0; RR pointer = 0. Reset mid-transfer discards all buffered entries and the output register.
- Channel write: when req_val_i[i] && req_rdy_o[i], {BASE_QUEUE_ID+i, req_data_i[i]} is written at the clock edge. req_rdy_o[i] = !full[i], combinational from state only, with no dependence on req_val_i or on a same-cycle pop. A pop does not free the slot for a write in the same cycle.
- FIFO order: FIFO order per channel. Read/write pointers wrap modulo FIFO_DEPTH. Count range is 0..FIFO_DEPTH.
- Output register load: load_en = !buffered_req_val_o || buffered_req_rdy_i.
  - When load_en and any FIFO is non-empty, the arbiter grants one channel. That channel's head is popped and loaded into the output register, and buffered_req_val_o is set to 1.
  - When load_en and all FIFOs are empty, buffered_req_val_o is cleared to 0.
- Arbitration: round-robin. Search starts at the RR pointer. The first non-empty channel at or after the pointer (wrapping) wins. After each grant, pointer = (winner+1) mod NUM_CH. The pointer is unchanged when there is no grant.
- Fairness bound: no non-empty channel waits more than NUM_CH-1 grants.
- Stall: while buffered_req_val_o && !buffered_req_rdy_i, the output register holds its data stable. There is no pop and the pointer is unchanged.
- Latency: an entry accepted at edge t appears on the output no earlier than edge t+1 (visible the cycle after the FIFO write). There is no input-to-output combinational path.
- Throughput: 1 entry/cycle aggregate with continuous downstream ready.
- Simultaneous write and pop on the same channel: both occur; count is unchanged.
- Empty-FIFO write is not bypassed; it is visible to the arbiter the next cycle.
- NUM_CH=1 degenerates to a single-channel buffer plus output register; the pointer is held at 0.
- Elaboration error if NUM_CH < 1, FIFO_DEPTH < 2, or BASE_QUEUE_ID+NUM_CH-1 exceeds the MSG_ID_SIZE range.

Optional Feature:
FALAFEL_INBUF_OCCUPANCY_EN
- Defined: adds output occupancy_o, NUM_CH x $clog2(FIFO_DEPTH+1), giving the per-channel FIFO count, registered with the FIFO state. Also adds drop_err_o, NUM_CH, a sticky flag set when req_val_i[i] && !req_rdy_o[i] (a stall observed). It is cleared only by reset.
- Undefined: neither port exists and no counters are synthesised. Functional behaviour is otherwise identical.

Decomposition:
- falafel_pkg (existing) supplies DATA_W, MSG_ID_SIZE and alloc_entry_t.
- Add to falafel_pkg: the function ch_queue_id(base, idx) and the constant INBUF_MAX_CH = 2**MSG_ID_SIZE.
- Per-channel storage: one FIFO per channel, instantiated in a generate loop. The existing falafel_fifo may be reused with rst_ni driven by !rst_i.
- Natural sub-module: falafel_rr_arbiter, parameterised by NUM_CH. Inputs: req vector, advance. Outputs: one-hot grant, grant index. It owns the RR pointer.

Test Plan:
1. Reset then idle -> req_rdy_o=2'b11, buffered_req_val_o=0, data=0.
2. NUM_CH=2, BASE_QUEUE_ID=4: write ch0 0xA at t0, rdy_i=1 -> output at t1 = {4,0xA}, val=1 for one cycle.
3. Both channels write every cycle (ch0 0x10,0x11; ch1 0x20,0x21), rdy_i=1 -> output order {4,0x10},{5,0x20},{4,0x11},{5,0x21}.
4. rdy_i=0, FIFO_DEPTH=2: write 3 entries to ch1 -> output holds the first entry stable; ch1 FIFO holds 2; req_rdy_o[1]=0. Raise rdy_i -> entries drain in order and req_rdy_o[1] returns to 1 the cycle after the first pop.
5. Only ch1 active with a pointer at 1 after grant wraps to 0 -> ch1 still granted every cycle (no idle bubbles), order preserved.
6. Assert rst_i mid-stream with 2 entries buffered and val=1 -> outputs clear immediately (async). After release, no stale entry appears. With FALAFEL_INBUF_OCCUPANCY_EN: occupancy_o=0 and drop_err_o=0.
